// File: rtl/asg_lin_sat_pkg.sv
// Shared DSP helpers for stream scaling blocks.
// Provides a signed saturate function that reduces a value to a narrower
// signed width. It returns the saturated value and a clip flag.
package asg_lin_sat_pkg;

    localparam int unsigned SAT_MAXW = 32;

    typedef struct packed {
        logic signed [SAT_MAXW-1:0] val;
        logic                       clip;
    } sat_res_t;

    // Clamp x to the signed range of dwo bits (dwo <= SAT_MAXW).
    function automatic sat_res_t sat_signed(input logic signed [SAT_MAXW-1:0] x,
                                            input int unsigned              dwo);
        logic signed [SAT_MAXW-1:0] hi;
        logic signed [SAT_MAXW-1:0] lo;
        sat_res_t                   r;
        hi     = 32'sh7fff_ffff >>> (SAT_MAXW - dwo);
        lo     = ~hi;
        r.val  = x;
        r.clip = 1'b0;
        if (x > hi) begin
            r.val  = hi;
            r.clip = 1'b1;
        end else if (x < lo) begin
            r.val  = lo;
            r.clip = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/asg_lin_sat.sv
// Gain/offset/saturate stage between the ASG stream and the DAC stream.
// Ports:
//   clk, rst           stream clock, synchronous active-high reset
//   sti_*_i / sti_*_o  input AXI4-stream (TDATA/TKEEP/TLAST/TVALID in, TREADY out)
//   sto_*_o / sto_*_i  output AXI4-stream (TDATA/TKEEP/TLAST/TVALID out, TREADY in)
//   ctl_rst_i          pipeline flush and status clear
//   cfg_mul_i          signed gain, s1.(DWM-2)
//   cfg_sum_i          signed offset in output LSBs
//   sts_sat_o          saturating count of clipped beats
//   sts_flg_o          sticky clip flag
module asg_lin_sat
    import asg_lin_sat_pkg::*;
#(
    parameter  int unsigned DWI  = 14,
    parameter  int unsigned DWO  = 14,
    parameter  int unsigned DWM  = 16,
    parameter  int unsigned CWS  = 16,
    localparam int unsigned KWI  = (DWI + 7) / 8,
    localparam int unsigned KWO  = (DWO + 7) / 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DWI-1:0] sti_tdata_i,
    input  logic [KWI-1:0] sti_tkeep_i,
    input  logic           sti_tlast_i,
    input  logic           sti_tvalid_i,
    output logic           sti_tready_o,
    output logic [DWO-1:0] sto_tdata_o,
    output logic [KWO-1:0] sto_tkeep_o,
    output logic           sto_tlast_o,
    output logic           sto_tvalid_o,
    input  logic           sto_tready_i,
    input  logic           ctl_rst_i,
    input  logic [DWM-1:0] cfg_mul_i,
    input  logic [DWO-1:0] cfg_sum_i,
    output logic [CWS-1:0] sts_sat_o,
    output logic           sts_flg_o
);

    localparam int unsigned PW  = DWI + DWM;
    localparam int unsigned SHW = DWI + 2;
    localparam int unsigned SW  = ((SHW > DWO) ? SHW : DWO) + 1;

    // Stage 1: captured sample and configuration
    logic                  v1_q;
    logic signed [DWI-1:0] d1_q;
    logic signed [DWM-1:0] m1_q;
    logic signed [DWO-1:0] o1_q;
    logic                  l1_q;
    // Stage 2: scaled sample and offset
    logic                  v2_q;
    logic signed [SHW-1:0] shf2_q;
    logic signed [DWO-1:0] o2_q;
    logic                  l2_q;
    // Stage 3: saturated output beat
    logic                  v3_q;
    logic        [DWO-1:0] d3_q;
    logic                  l3_q;
    // Status
    logic        [CWS-1:0] cnt_q, cnt_d;
    logic                  flg_q, flg_d;

    logic                  en;
    logic signed [PW-1:0]  prd;
    logic signed [SHW-1:0] shf2_d;
    logic signed [SW-1:0]  sum;
    sat_res_t              sat;
    logic                  clr;

    // Datapath and status next-state
    always_comb begin
        en     = sto_tready_i | ~v3_q;
        clr    = rst | ctl_rst_i;
        prd    = PW'(d1_q) * PW'(m1_q);
        shf2_d = SHW'(prd >>> (DWM - 2));
        sum    = SW'(shf2_q) + SW'(o2_q);
        sat    = sat_signed(SAT_MAXW'(sum), DWO);
        cnt_d  = cnt_q;
        flg_d  = flg_q;
        // A clip is counted as the beat moves from stage 2 into stage 3
        if (en && v2_q && sat.clip) begin
            flg_d = 1'b1;
            if (cnt_q != {CWS{1'b1}}) begin
                cnt_d = cnt_q + CWS'(1);
            end
        end
    end

    // Pipeline registers; data fields only load when their stage takes a beat
    always_ff @(posedge clk) begin
        if (clr) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            cnt_q <= '0;
            flg_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            flg_q <= flg_d;
            if (en) begin
                v1_q <= sti_tvalid_i;
                v2_q <= v1_q;
                v3_q <= v2_q;
                if (sti_tvalid_i) begin
                    d1_q <= sti_tdata_i;
                    m1_q <= cfg_mul_i;
                    o1_q <= cfg_sum_i;
                    l1_q <= sti_tlast_i;
                end
                if (v1_q) begin
                    shf2_q <= shf2_d;
                    o2_q   <= o1_q;
                    l2_q   <= l1_q;
                end
                if (v2_q) begin
                    d3_q <= sat.val[DWO-1:0];
                    l3_q <= l2_q;
                end
            end
        end
    end

    // Input TKEEP carries no information for a sample stream
    logic unused_in;
    assign unused_in = ^{sti_tkeep_i, sat.val[SAT_MAXW-1:DWO]};

    assign sti_tready_o = en;
    assign sto_tdata_o  = d3_q;
    assign sto_tkeep_o  = {KWO{1'b1}};
    assign sto_tlast_o  = l3_q;
    assign sto_tvalid_o = v3_q;
    assign sts_sat_o    = cnt_q;
    assign sts_flg_o    = flg_q;

endmodule
